// File: rtl/adc_serial_rx.sv
// adc_serial_rx: receive-side deframer for the ADC controller serial stream.
// Rebuilds each DATA_W-bit successive-approximation result (MSB first) from
// SerialInput, bounded by DataMark (frame start) and LoadReg (frame end, LSB
// present in the same cycle). Results go downstream on a valid/ready
// handshake. Malformed frames pulse frame_err; results lost before being
// consumed set the sticky overrun flag.
module adc_serial_rx #(
  parameter int DATA_W  = 8,
  parameter int MIN_GAP = DATA_W + 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              SerialInput,
  input  logic              DataMark,
  input  logic              LoadReg,
  input  logic              rx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              overrun,
  output logic [7:0]        frame_cnt
);

  // Counter only has to reach MIN_GAP, where it saturates.
  localparam int GAP_W = $clog2(MIN_GAP + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [GAP_W-1:0]    gap_r;
  logic [GAP_W-1:0]    gap_nxt_s;
  logic [DATA_W-2:0]   sr_r;
  logic [DATA_W-1:0]   capture_s;
  logic                good_s;
  logic                bad_s;

  logic [DATA_W-1:0]   rx_data_r;
  logic [DATA_W-1:0]   rx_data_nxt_s;
  logic                rx_valid_r;
  logic                rx_valid_nxt_s;
  logic                frame_err_r;
  logic                overrun_r;
  logic                overrun_nxt_s;
  logic [7:0]          frame_cnt_r;
  logic [7:0]          frame_cnt_nxt_s;

  // The LSB arrives on SerialInput in the LoadReg cycle itself, so the
  // captured word is the shifted history plus the live bit.
  assign capture_s = {sr_r, SerialInput};

  // Classify a LoadReg against the current state, then pick the next state.
  // LoadReg is judged first; a coincident DataMark then opens the next frame.
  always_comb begin
    state_nxt_s = state_r;
    gap_nxt_s   = gap_r;
    good_s      = 1'b0;
    bad_s       = 1'b0;

    case (state_r)
      IDLE: begin
        if (LoadReg) begin
          bad_s = 1'b1;
        end else begin
          bad_s = 1'b0;
        end
      end
      ARMED: begin
        if (LoadReg) begin
          // Counter is pre-increment here: edges since DataMark minus one.
          if (gap_r >= GAP_W'(MIN_GAP - 1)) begin
            good_s = 1'b1;
          end else begin
            bad_s = 1'b1;
          end
        end else begin
          good_s = 1'b0;
        end
      end
      default: begin
        bad_s = LoadReg;
      end
    endcase

    if (DataMark) begin
      state_nxt_s = ARMED;
      gap_nxt_s   = {GAP_W{1'b0}};
    end else if (LoadReg) begin
      state_nxt_s = IDLE;
      gap_nxt_s   = {GAP_W{1'b0}};
    end else if (state_r == ARMED) begin
      // Start wait can be arbitrarily long, so saturate instead of wrapping.
      if (gap_r < GAP_W'(MIN_GAP)) begin
        gap_nxt_s = gap_r + GAP_W'(1);
      end else begin
        gap_nxt_s = gap_r;
      end
    end else begin
      state_nxt_s = IDLE;
      gap_nxt_s   = {GAP_W{1'b0}};
    end
  end

  // Next values for the handshake-facing registers; a good capture wins over
  // a consume on the same edge.
  always_comb begin
    rx_data_nxt_s   = rx_data_r;
    rx_valid_nxt_s  = rx_valid_r;
    overrun_nxt_s   = overrun_r;
    frame_cnt_nxt_s = frame_cnt_r;

    if (good_s) begin
      rx_data_nxt_s   = capture_s;
      rx_valid_nxt_s  = 1'b1;
      frame_cnt_nxt_s = frame_cnt_r + 8'd1;
      if (rx_valid_r && !rx_ready) begin
        overrun_nxt_s = 1'b1;
      end else begin
        overrun_nxt_s = overrun_r;
      end
    end else if (rx_valid_r && rx_ready) begin
      rx_valid_nxt_s = 1'b0;
    end else begin
      rx_valid_nxt_s = rx_valid_r;
    end
  end

  // Free-running shift register and frame tracker state.
  always_ff @(posedge clk) begin
    if (clr) begin
      sr_r    <= {(DATA_W-1){1'b0}};
      state_r <= IDLE;
      gap_r   <= {GAP_W{1'b0}};
    end else begin
      sr_r    <= {sr_r[DATA_W-3:0], SerialInput};
      state_r <= state_nxt_s;
      gap_r   <= gap_nxt_s;
    end
  end

  // Registered outputs; reset discards any frame in flight.
  always_ff @(posedge clk) begin
    if (clr) begin
      rx_data_r   <= {DATA_W{1'b0}};
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
      frame_cnt_r <= 8'd0;
    end else begin
      rx_data_r   <= rx_data_nxt_s;
      rx_valid_r  <= rx_valid_nxt_s;
      frame_err_r <= bad_s;
      overrun_r   <= overrun_nxt_s;
      frame_cnt_r <= frame_cnt_nxt_s;
    end
  end

  assign rx_data   = rx_data_r;
  assign rx_valid  = rx_valid_r;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;
  assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_adc_serial_rx.sv
// Bench for adc_serial_rx: a cycle-indexed model (bit log plus "cycle of last
// DataMark") predicts every output each cycle; directed scenarios add literal
// expectations that pin the model.
module tb_adc_serial_rx;

  localparam int DATA_W  = 8;
  localparam int MIN_GAP = DATA_W + 1;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       SerialInput = 1'b0;
  logic       DataMark = 1'b0;
  logic       LoadReg = 1'b0;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic [7:0] frame_cnt;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  adc_serial_rx #(.DATA_W(DATA_W), .MIN_GAP(MIN_GAP)) dut (
    .clk(clk), .clr(clr), .SerialInput(SerialInput), .DataMark(DataMark),
    .LoadReg(LoadReg), .rx_ready(rx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .frame_err(frame_err), .overrun(overrun),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit         bitlog [0:8191];
  int         cyc      = 0;
  int         rst_cyc  = -1;
  int         mark_cyc = 0;
  bit         armed    = 1'b0;
  logic [7:0] m_data   = 8'h00;
  bit         m_valid  = 1'b0;
  bit         m_err    = 1'b0;
  bit         m_ovr    = 1'b0;
  int         m_cnt    = 0;

  always @(posedge clk) begin
    logic [7:0] cap;
    if (clr) begin
      m_data = 8'h00; m_valid = 1'b0; m_err = 1'b0; m_ovr = 1'b0; m_cnt = 0;
      armed = 1'b0; rst_cyc = cyc;
    end else begin
      bitlog[cyc] = SerialInput;
      m_err = 1'b0;
      if (LoadReg && armed && (cyc - mark_cyc) >= MIN_GAP) begin
        // Result bit k was on the line k cycles before LoadReg.
        for (int k = 0; k < 8; k++)
          cap[k] = (cyc - k > rst_cyc) ? bitlog[cyc - k] : 1'b0;
        if (m_valid && !rx_ready) m_ovr = 1'b1;
        m_data  = cap;
        m_valid = 1'b1;
        m_cnt   = (m_cnt + 1) % 256;
      end else begin
        if (LoadReg) m_err = 1'b1;
        if (m_valid && rx_ready) m_valid = 1'b0;
      end
      if (LoadReg) armed = 1'b0;
      if (DataMark) begin
        armed = 1'b1;
        mark_cyc = cyc;
      end
    end
    cyc++;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model rx_data", int'(rx_data), int'(m_data));
      check("model rx_valid", int'(rx_valid), int'(m_valid));
      check("model frame_err", int'(frame_err), int'(m_err));
      check("model overrun", int'(overrun), int'(m_ovr));
      check("model frame_cnt", int'(frame_cnt), m_cnt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit s, input bit dm, input bit lr);
    SerialInput = s; DataMark = dm; LoadReg = lr;
    @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] v, input int wait_n,
                       input bit mark, input bit mark_end);
    if (mark) drive(1'b0, 1'b1, 1'b0);
    repeat (wait_n) drive(1'b0, 1'b0, 1'b0);
    for (int i = 7; i >= 0; i--)
      drive(v[i], (i == 0) && mark_end, i == 0);
    SerialInput = 1'b0; DataMark = 1'b0; LoadReg = 1'b0;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    // Reset state
    check("reset rx_data", int'(rx_data), 0);
    check("reset rx_valid", int'(rx_valid), 0);
    check("reset frame_cnt", int'(frame_cnt), 0);
    clr = 1'b0;

    // Nominal 0xB2, consumed immediately
    rx_ready = 1'b1;
    frame(8'hB2, 1, 1'b1, 1'b0);
    check("nominal data", int'(rx_data), 'hB2);
    check("nominal valid", int'(rx_valid), 1);
    check("nominal cnt", int'(frame_cnt), 1);
    check("nominal err", int'(frame_err), 0);
    drive(1'b0, 1'b0, 1'b0);
    check("nominal consumed", int'(rx_valid), 0);

    // Back-to-back with no consumer
    do_reset();
    rx_ready = 1'b0;
    frame(8'hFF, 1, 1'b1, 1'b0);
    check("b2b first data", int'(rx_data), 'hFF);
    check("b2b first valid", int'(rx_valid), 1);
    check("b2b no overrun yet", int'(overrun), 0);
    frame(8'h01, 1, 1'b1, 1'b0);
    check("b2b second data", int'(rx_data), 'h01);
    check("b2b overrun", int'(overrun), 1);
    check("b2b cnt", int'(frame_cnt), 2);
    rx_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("b2b overrun sticky", int'(overrun), 1);

    // Malformed frames
    do_reset();
    drive(1'b1, 1'b0, 1'b1);
    check("orphan LoadReg err", int'(frame_err), 1);
    drive(1'b0, 1'b0, 1'b0);
    check("orphan err one cycle", int'(frame_err), 0);
    drive(1'b0, 1'b1, 1'b0);
    repeat (4) drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    check("short gap err", int'(frame_err), 1);
    check("short gap valid", int'(rx_valid), 0);
    check("short gap cnt", int'(frame_cnt), 0);
    drive(1'b0, 1'b0, 1'b0);

    // Long Start wait, then restarted wait
    frame(8'h5A, 40, 1'b1, 1'b0);
    check("long wait data", int'(rx_data), 'h5A);
    drive(1'b0, 1'b1, 1'b0);
    repeat (20) drive(1'b0, 1'b0, 1'b0);
    frame(8'h5A, 19, 1'b1, 1'b0);
    check("restart data", int'(rx_data), 'h5A);
    check("restart cnt", int'(frame_cnt), 2);

    // Coincident DataMark/LoadReg chains into the next frame
    frame(8'h3C, 1, 1'b1, 1'b1);
    check("coincident data", int'(rx_data), 'h3C);
    frame(8'hC3, 1, 1'b0, 1'b0);
    check("chained data", int'(rx_data), 'hC3);
    check("chained err", int'(frame_err), 0);
    check("chained cnt", int'(frame_cnt), 4);

    // Reset mid-frame
    rx_ready = 1'b0;
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0);
    clr = 1'b1;
    drive(1'b1, 1'b0, 1'b0);
    check("midreset data", int'(rx_data), 0);
    check("midreset cnt", int'(frame_cnt), 0);
    drive(1'b1, 1'b0, 1'b1);
    check("midreset valid", int'(rx_valid), 0);
    check("midreset err", int'(frame_err), 0);
    clr = 1'b0;
    repeat (3) drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    check("post reset stale LoadReg err", int'(frame_err), 1);
    frame(8'h81, 1, 1'b1, 1'b0);
    check("post reset data", int'(rx_data), 'h81);
    check("post reset cnt", int'(frame_cnt), 1);
    drive(1'b0, 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_serial_rx.md
# adc_serial_rx

Receive-side deframer for the ADC controller's serial conversion stream. It samples the controller's serial bit output, DataMark frame-start pulse and LoadReg frame-end pulse. It rebuilds each 8-bit successive-approximation result MSB first and presents it downstream on a valid/ready handshake. It also flags malformed frames and overrun.

## Interface
- DATA_W, 8: result width in bits; frame needs DATA_W serial bits.
- MIN_GAP, DATA_W+1: minimum clk edges from the DataMark sample to the LoadReg sample for a well-formed frame.
- clk  input  1  sole clock, rising edge.
- clr  input  1  reset, synchronous, active-high. The clock is single; the polarity and synchronicity are fixed.
- SerialInput  input  1  serial comparator bit stream, MSB first, one bit per clk.
- DataMark  input  1  one-cycle frame-start pulse.
- LoadReg  input  1  one-cycle frame-end pulse; the final bit (LSB) is on SerialInput in the same cycle.
- rx_ready  input  1  downstream accepts rx_data when high together with rx_valid.
- rx_data  output  DATA_W  last captured result.
- rx_valid  output  1  rx_data holds an unconsumed result.
- frame_err  output  1  one-cycle pulse: the captured frame was malformed.
- overrun  output  1  sticky: a result was overwritten before it was consumed.
- frame_cnt  output  8  count of good frames captured, wraps at 255→0.

## Operation
- Shift register sr[DATA_W-2:0] shifts on every clk: sr <= {sr[DATA_W-3:0], SerialInput}. This is unconditional, so it does not depend on when Start occurs.
- Capture value = {sr[DATA_W-2:0], SerialInput}, taken at the edge where LoadReg=1.
- Frame tracker FSM, states IDLE and ARMED:
  - IDLE → ARMED on DataMark=1; gap counter is set to 0.
  - ARMED: gap counter increments by 1 per edge and saturates at MIN_GAP.
  - DataMark while ARMED restarts: gap counter goes to 0 and the state stays ARMED.
  - LoadReg in either state → IDLE.
- Good frame: LoadReg=1 while ARMED with gap counter ≥ MIN_GAP-1. At that edge the counter is pre-increment, which equals the edge count minus 1.
  - On a good frame: rx_data <= capture, rx_valid <= 1, frame_cnt increments.
  - If rx_valid=1 and rx_ready=0 at that edge, overrun <= 1 and the new data overwrites rx_data.
- Bad frame: LoadReg=1 in IDLE, or while ARMED with too small a gap.
  - frame_err pulses high for 1 cycle.
  - rx_data, rx_valid and frame_cnt are unchanged; the tracker returns to IDLE.
- DataMark and LoadReg in the same cycle:
  - LoadReg is evaluated first against the current state.
  - The tracker then goes to ARMED with gap counter = 0, so the DataMark starts the next frame.
- Handshake: when rx_valid && rx_ready, rx_valid <= 0 on that edge. Good-frame capture has priority: if a good frame and a consume occur on the same edge, rx_valid stays 1 with the new data and overrun is not set.
- Reset (clr=1 at an edge, at any time including mid-frame):
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0, frame_cnt=0.
  - sr=0, state IDLE, gap counter 0.
  - The aborted frame is discarded.

## Timing
- Capture latency: rx_data and rx_valid update on the same edge that samples LoadReg=1 and are visible the following cycle.
- frame_err is asserted in the cycle after the bad LoadReg sample and is high for exactly 1 cycle.
- Controller alignment: SerialInput is the controller's registered comparator output, one cycle late.
  - Bit 7 (MSB) is on SerialInput DATA_W-1 cycles before the LoadReg cycle.
  - Bit 0 is on SerialInput in the LoadReg cycle.
- Minimum controller frame is DataMark at edge E0 and LoadReg at edge E9. That is 9 edges apart, which equals MIN_GAP for DATA_W=8.
- The Start wait between DataMark and the first bit may be any length; the gap counter saturates and is not limited.
- rx_ready is sampled only at clk edges. rx_valid does not depend combinationally on rx_ready.
- All outputs are registered.

## Test plan
- Nominal frame: DataMark at E0, serial bits 1,0,1,1,0,0,1,0 on E2..E9, LoadReg at E9, rx_ready=1 → rx_data=0xB2 and rx_valid=1 for 1 cycle, frame_cnt=1, frame_err=0.
- Back-to-back frames 0xFF then 0x01 with rx_ready=0 → after the first, rx_valid=1 and rx_data=0xFF; after the second, rx_data=0x01, overrun=1 (sticky), frame_cnt=2.
- LoadReg with no DataMark (after reset), and LoadReg 5 edges after DataMark → frame_err pulses once each; rx_valid stays 0 and frame_cnt stays 0.
- Long Start wait: DataMark, 40 idle cycles, then 8 bits of 0x5A and LoadReg → rx_data=0x5A; a second DataMark mid-wait restarts the frame and still gives 0x5A.
- DataMark and LoadReg coincident at the end of a good 0x3C frame → 0x3C captured, tracker ARMED; next LoadReg 9 edges later with 0xC3 → 0xC3 captured with no frame_err.
- clr=1 asserted mid-frame after 4 bits, released, then a full 0x81 frame → every output reads 0 during reset; the partial frame produces no output; 0x81 is then captured with frame_cnt=1.
